serial_addsub_unit: RTL and testbench
=====================================

# serial_addsub_unit

Bit-serial adder/subtractor datapath unit for the ALU. It consumes the add/subtract selection that drives the adder carry-in: carry-in = 0 for add, 1 for subtract, with B inverted on subtract. It accepts one operation per START handshake and processes one bit per clock, LSB first. It returns the WIDTH-bit result with carry-out, signed-overflow and zero flags and a one-cycle DONE pulse. It serves area-constrained ALU builds in place of the parallel adder.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- CLK  in  1  system clock; all state changes on rising edge
- RST_N  in  1  synchronous, active-low reset, sampled on the rising edge of CLK
- START  in  1  request; sampled only when BUSY=0
- OP  in  1  0 = add (A+B), 1 = subtract (A-B); captured with START
- A  in  WIDTH  operand A; captured with START
- B  in  WIDTH  operand B; captured with START
- BUSY  out  1  high while in RUN or FIN
- DONE  out  1  one-cycle pulse; RESULT and flags are valid from this cycle on
- RESULT  out  WIDTH  sum/difference, modulo 2^WIDTH
- COUT  out  1  final carry; on subtract, 1 = no borrow (A >= B unsigned)
- OVF  out  1  two's-complement overflow
- ZERO  out  1  RESULT == 0

## Operation
- States: IDLE, RUN, FIN.
- IDLE: when START=1 at an edge:
  - load shift registers with A and B; B is inverted when OP=1
  - load the carry register with OP (the carry-in selection)
  - clear the bit counter; go to RUN
- START=0 in IDLE: hold all outputs.
- RUN, each edge:
  - s = a0 ^ b0 ^ c; c' = majority(a0, b0, c)
  - shift s into the result register MSB, shift right
  - shift A and B right; counter += 1
  - on the edge that processes bit WIDTH-2, also latch c' as c_msb_in (carry into the MSB)
- RUN, edge with counter == WIDTH-1 (MSB processed):
  - go to FIN
  - register RESULT from the shift register (including this s)
  - COUT = c'; OVF = c_msb_in ^ c'; ZERO = (full result == 0)
- FIN: DONE=1 for exactly this cycle; the next edge returns to IDLE.
- RESULT, COUT, OVF and ZERO hold their last values until the next DONE. They do not change during RUN.
- START while BUSY=1 is ignored: not queued, no effect on the operation in flight.
- OP, A and B are don't-care except on the accepting edge. Changes during RUN have no effect.
- START in the FIN cycle is ignored. The earliest accept is the first IDLE cycle.
- Reset, at any edge with RST_N=0:
  - state IDLE; counter, shift registers and carry cleared
  - BUSY, DONE, RESULT, COUT, OVF, ZERO all 0
- Reset mid-RUN aborts the operation. No DONE is produced and the outputs read 0.
- Reset has priority over START at the same edge.

## Timing
- Accepting edge k, then RUN edges k+1 .. k+WIDTH, then FIN for the cycle after edge k+WIDTH.
- DONE is high between edges k+WIDTH and k+WIDTH+1. Latency START-accept to DONE = WIDTH+1 edges.
- BUSY rises after edge k and falls after edge k+WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles with START held high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Add, WIDTH=8: A=0x05, B=0x03, OP=0, START accepted at edge k.
  - DONE high after edge k+8 only, RESULT=0x08, COUT=0, OVF=0, ZERO=0
  - BUSY high for 9 cycles
- Subtract with borrow: A=0x03, B=0x05, OP=1 -> RESULT=0xFE, COUT=0, OVF=0, ZERO=0.
- Overflow:
  - 0x7F+0x01 -> RESULT=0x80, OVF=1, COUT=0
  - 0x80-0x01 -> RESULT=0x7F, OVF=1, COUT=1
- Zero and no borrow: 0x5A-0x5A -> RESULT=0x00, ZERO=1, COUT=1, OVF=0. Also 0xFF+0x01 -> RESULT=0x00, ZERO=1, COUT=1, OVF=0.
- START ignored during operation: start 0x10+0x20, then at RUN edge 3 assert START with A=0xFF, B=0xFF, OP=1.
  - single DONE with RESULT=0x30
  - START held through FIN is accepted only in the following IDLE cycle
- Reset mid-operation: start 0x11+0x22, drive RST_N=0 at RUN edge 4 for one edge.
  - all outputs 0 and BUSY=0 the next cycle; no DONE
  - a fresh 0x01+0x01 afterwards returns 0x02 with normal latency

Source files
------------

// File: rtl/serial_addsub_unit_if.sv
// serial_addsub_unit_if
//   Bundles the request and result signals of the bit-serial adder/subtractor.
//
//   Signals:
//     start  - request; sampled only while busy is low
//     op     - 0 = add (a + b), 1 = subtract (a - b); captured with start
//     a, b   - operands; captured with start
//     busy   - high while an operation is in flight
//     done   - one-cycle pulse; result and flags are valid from this cycle on
//     result - sum/difference modulo 2^WIDTH
//     cout   - final carry (on subtract, 1 = no borrow)
//     ovf    - two's-complement overflow
//     zero   - result == 0
//
//   Handshake: a request is accepted on a rising clock edge where start=1
//   and busy=0. There is no backpressure and no queuing: start seen while
//   busy=1 (including the done cycle) is dropped. Each accepted request
//   produces exactly one done pulse unless reset intervenes.
interface serial_addsub_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, cout, ovf, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, cout, ovf, zero
    );
endinterface

// File: rtl/serial_addsub_unit.sv
// serial_addsub_unit
//   Bit-serial adder/subtractor. One operation per accepted start, one bit
//   per clock, LSB first. Subtraction is A + ~B + 1, with the +1 supplied
//   as the initial carry.
//
//   Ports:
//     clk       - system clock, rising edge
//     rst_n     - synchronous active-low reset
//     bus       - request/result bundle (slave side)
//     state_dbg - current FSM state (0 = IDLE, 1 = RUN, 2 = FIN)
//
//   Timing: accept at edge k, bits processed on edges k+1..k+WIDTH, done
//   high for the cycle after edge k+WIDTH, back to IDLE at edge k+WIDTH+1.
module serial_addsub_unit #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_addsub_unit_if.slave  bus,
    output logic [1:0]           state_dbg
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_r;
    logic             c;
    logic             c_msb_in;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] r_next;
    logic             last_bit;
    logic             msb_carry_bit;

    // Full-adder slice on the current LSBs; the sum enters the result at
    // the MSB so after WIDTH shifts bit 0 has reached position 0.
    always_comb begin
        s             = sh_a[0] ^ sh_b[0] ^ c;
        c_next        = (sh_a[0] & sh_b[0]) | (sh_a[0] & c) | (sh_b[0] & c);
        r_next        = {s, sh_r[WIDTH-1:1]};
        last_bit      = (cnt == CW'(WIDTH - 1));
        msb_carry_bit = (cnt == CW'(WIDTH - 2));
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sh_a       <= '0;
            sh_b       <= '0;
            sh_r       <= '0;
            c          <= 1'b0;
            c_msb_in   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.cout   <= 1'b0;
            bus.ovf    <= 1'b0;
            bus.zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        sh_a     <= bus.a;
                        sh_b     <= bus.op ? ~bus.b : bus.b;
                        c        <= bus.op;
                        cnt      <= '0;
                        sh_r     <= '0;
                        bus.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sh_a <= sh_a >> 1;
                    sh_b <= sh_b >> 1;
                    sh_r <= r_next;
                    c    <= c_next;
                    cnt  <= cnt + 1'b1;
                    // Carry into the MSB, needed for the overflow flag.
                    if (msb_carry_bit) begin
                        c_msb_in <= c_next;
                    end
                    if (last_bit) begin
                        bus.result <= r_next;
                        bus.cout   <= c_next;
                        bus.ovf    <= c_msb_in ^ c_next;
                        bus.zero   <= (r_next == '0);
                        bus.done   <= 1'b1;
                        state      <= FIN;
                    end
                end
                FIN: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_unit.sv
// tb_serial_addsub_unit
//   Bench for serial_addsub_unit at WIDTH=8: directed cases with literal
//   expectations, then randomized traffic (including stray start and reset
//   pulses) checked every cycle against an arithmetic model.
module tb_serial_addsub_unit;
    localparam int W = 8;

    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         total = 0;
    int         bad = 0;
    bit         chk_en = 0;

    serial_addsub_unit_if #(.WIDTH(W)) bus ();

    serial_addsub_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [W-1:0] result;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    function automatic res_t ref_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic o);
        res_t r;
        int ua, ub, sa, sb, us, ss;
        ua = int'(av);
        ub = int'(bv);
        sa = av[W-1] ? ua - (1 << W) : ua;
        sb = bv[W-1] ? ub - (1 << W) : ub;
        if (o) begin
            us     = ua - ub;
            ss     = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            us     = ua + ub;
            ss     = sa + sb;
            r.cout = (us >= (1 << W));
        end
        r.result = us[W-1:0];
        r.ovf    = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
        r.zero   = (r.result == '0);
        return r;
    endfunction

    // rem counts the busy cycles still to come for the operation in flight.
    int   rem = 0;
    res_t pend;
    res_t m_out;
    logic m_busy, m_done;

    always @(posedge clk) begin
        if (!rst_n) begin
            rem   = 0;
            m_out = '0;
        end else if (rem > 0) begin
            rem--;
            if (rem == 1) m_out = pend;
        end else if (bus.start) begin
            pend = ref_op(bus.a, bus.b, bus.op);
            rem  = W + 1;
        end
        m_busy = (rem > 0);
        m_done = (rem == 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",   32'(bus.busy),   32'(m_busy));
            check("done",   32'(bus.done),   32'(m_done));
            check("result", 32'(bus.result), 32'(m_out.result));
            check("cout",   32'(bus.cout),   32'(m_out.cout));
            check("ovf",    32'(bus.ovf),    32'(m_out.ovf));
            check("zero",   32'(bus.zero),   32'(m_out.zero));
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv, input logic o);
        bus.start = s;
        bus.a     = av;
        bus.b     = bv;
        bus.op    = o;
    endtask

    // One operation from an idle unit, with literal expectations.
    task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic o, input logic [W-1:0] er, input logic ec,
                          input logic eo, input logic ez);
        int busy_cycles = 0;
        int done_cycles = 0;
        @(negedge clk);
        drive(1'b1, av, bv, o);
        for (int i = 0; i < W + 1; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.busy) busy_cycles++;
            if (bus.done) done_cycles++;
        end
        check({name, "_done"},   32'(bus.done),   32'd1);
        check({name, "_result"}, 32'(bus.result), 32'(er));
        check({name, "_cout"},   32'(bus.cout),   32'(ec));
        check({name, "_ovf"},    32'(bus.ovf),    32'(eo));
        check({name, "_zero"},   32'(bus.zero),   32'(ez));
        check({name, "_ndone"},  32'(done_cycles), 32'd1);
        @(negedge clk);
        if (bus.busy) busy_cycles++;
        check({name, "_busy_len"}, 32'(busy_cycles), 32'(W + 1));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] corners [6];
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h5A};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return W'($urandom_range(0, (1 << W) - 1));
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset_busy",   32'(bus.busy),   32'd0);
        check("reset_done",   32'(bus.done),   32'd0);
        check("reset_result", 32'(bus.result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add",     8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op("sub_brw", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("add_ovf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_ovf", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("sub_zero",8'h5A, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("add_wrap",8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // START during RUN is dropped; START held through FIN is taken in
        // the first IDLE cycle.
        @(negedge clk);
        drive(1'b1, 8'h10, 8'h20, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        repeat (W - 2) @(negedge clk);
        check("ign_done",   32'(bus.done),   32'd1);
        check("ign_result", 32'(bus.result), 32'h30);
        @(negedge clk);
        check("fin_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("held_accept_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        repeat (W) @(negedge clk);
        check("held_done",   32'(bus.done),   32'd1);
        check("held_result", 32'(bus.result), 32'h00);
        check("held_zero",   32'(bus.zero),   32'd1);
        check("held_cout",   32'(bus.cout),   32'd1);
        @(negedge clk);

        // Reset in the middle of an operation.
        @(negedge clk);
        drive(1'b1, 8'h11, 8'h22, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_cout",   32'(bus.cout),   32'd0);
        check("rst_ovf",    32'(bus.ovf),    32'd0);
        check("rst_zero",   32'(bus.zero),   32'd0);
        repeat (W) @(negedge clk);
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        // Randomized traffic; the per-cycle compare covers it.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 2) == 0, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)));
            rst_n = ($urandom_range(0, 249) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0);
        repeat (W + 4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
